// File: rtl/ex_stage.sv
// ex_stage: execute stage between the ID/EX and EX/MEM pipeline registers.
// It resolves rs/rt forwarding from MEM and WB, selects operand 2 and the
// destination register, computes the ALU result, and registers everything
// into EX/MEM.
// Define EX_MULDIV_EN to build the iterative multiplier, the HI/LO
// registers and the stall logic. Without it, mult/multu/mfhi/mflo are NOPs.
module ex_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    input  logic [31:0] data_in_1,
    input  logic [31:0] data_in_2,
    input  logic [31:0] sextend_in,
    input  logic [31:0] zeroext_in,
    input  logic [4:0]  rs_in,
    input  logic [4:0]  rt_in,
    input  logic [4:0]  rd_in,
    input  logic [1:0]  op2_src_in,
    input  logic        reg_dst_in,
    input  logic        reg_write_in,
    input  logic        mem_reg_dst_in,
    input  logic        mem_write_in,
    input  logic        jal_in,
    input  logic        mem_fwd_we,
    input  logic [4:0]  mem_fwd_reg,
    input  logic [31:0] mem_fwd_data,
    input  logic        wb_fwd_we,
    input  logic [4:0]  wb_fwd_reg,
    input  logic [31:0] wb_fwd_data,
    output logic [31:0] alu_out,
    output logic [31:0] store_data_out,
    output logic [4:0]  write_reg_out,
    output logic        reg_write_out,
    output logic        mem_reg_dst_out,
    output logic        mem_write_out,
    output logic        stall_out
);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_ADDIU = 6'h09,
                           OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI   = 6'h0D,
                           OP_XORI  = 6'h0E, OP_LUI  = 6'h0F, OP_LW    = 6'h23,
                           OP_SW    = 6'h2B;
    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03,
                           F_MFHI = 6'h10, F_MFLO = 6'h12, F_MULT = 6'h18,
                           F_MULTU = 6'h19, F_ADD = 6'h20, F_ADDU = 6'h21,
                           F_SUB  = 6'h22, F_AND  = 6'h24, F_OR   = 6'h25,
                           F_XOR  = 6'h26, F_NOR  = 6'h27, F_SLT  = 6'h2A;

    logic [5:0]  opcode, funct;
    logic [4:0]  shamt, dest;
    logic        is_rtype, is_mult, is_mf, stall, kill_write;
    logic [31:0] rs_val, rt_val, op2, result;
    logic        unused_instr_bits;

    assign opcode   = instr_in[31:26];
    assign funct    = instr_in[5:0];
    assign shamt    = instr_in[10:6];
    assign is_rtype = (opcode == OP_RTYPE);
    assign is_mult  = is_rtype && (funct == F_MULT || funct == F_MULTU);
    assign is_mf    = is_rtype && (funct == F_MFHI || funct == F_MFLO);
    // Register indices arrive decoded on their own ports.
    assign unused_instr_bits = ^instr_in[25:16];

    // Forwarding: MEM beats WB, writes to register 0 never forward.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        rs_val = data_in_1;
        if (mem_fwd_we && mem_fwd_reg != 5'd0 && mem_fwd_reg == rs_in)
            rs_val = mem_fwd_data;
        else if (wb_fwd_we && wb_fwd_reg != 5'd0 && wb_fwd_reg == rs_in)
            rs_val = wb_fwd_data;
        rt_val = data_in_2;
        if (mem_fwd_we && mem_fwd_reg != 5'd0 && mem_fwd_reg == rt_in)
            rt_val = mem_fwd_data;
        else if (wb_fwd_we && wb_fwd_reg != 5'd0 && wb_fwd_reg == rt_in)
            rt_val = wb_fwd_data;
    end

    // Operand 2 and destination register selection.
    always_comb begin
        case (op2_src_in)
            2'd0:    op2 = rt_val;
            2'd1:    op2 = sextend_in;
            2'd2:    op2 = zeroext_in;
            default: op2 = 32'd0;
        endcase
        if (jal_in)          dest = 5'd31;
        else if (reg_dst_in) dest = rd_in;
        else                 dest = rt_in;
    end

`ifdef EX_MULDIV_EN
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      state;
    logic [4:0]  count;
    logic [31:0] mcand, hi, lo, rs_mag, rt_mag;
    logic [63:0] prod, step_prod, final_prod;
    logic [32:0] step_sum;
    logic        neg, signed_op;

    assign signed_op  = (funct == F_MULT);
    assign rs_mag     = (signed_op && rs_val[31]) ? 32'd0 - rs_val : rs_val;
    assign rt_mag     = (signed_op && rt_val[31]) ? 32'd0 - rt_val : rt_val;
    assign stall      = (state == BUSY) && (is_mult || is_mf);
    assign kill_write = is_mult;

    // One shift-add iteration: add multiplicand into the upper half when the
    // current multiplier bit is set, then shift the whole product right.
    always_comb begin
        step_sum   = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mcand} : 33'd0);
        step_prod  = {step_sum, prod[31:1]};
        final_prod = neg ? 64'd0 - step_prod : step_prod;
    end

    // Multiplier control: latch magnitudes on start, 32 iterations, then HI/LO.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            count <= 5'd0;
            mcand <= 32'd0;
            prod  <= 64'd0;
            neg   <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            case (state)
                IDLE: if (is_mult) begin
                    state <= BUSY;
                    count <= 5'd0;
                    mcand <= rs_mag;
                    prod  <= {32'd0, rt_mag};
                    neg   <= signed_op && (rs_val[31] ^ rt_val[31]);
                end
                BUSY: begin
                    prod  <= step_prod;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        {hi, lo} <= final_prod;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign stall      = 1'b0;
    assign kill_write = is_mult || is_mf;
`endif

    assign stall_out = stall;

    // ALU result; jal overrides the opcode decode.
    always_comb begin
        result = 32'd0;
        if (jal_in) begin
            result = pc_in + 32'd4;
        end else if (is_rtype) begin
            case (funct)
                F_ADD, F_ADDU: result = rs_val + op2;
                F_SUB:         result = rs_val - op2;
                F_AND:         result = rs_val & op2;
                F_OR:          result = rs_val | op2;
                F_XOR:         result = rs_val ^ op2;
                F_NOR:         result = ~(rs_val | op2);
                F_SLT:         result = {31'd0, $signed(rs_val) < $signed(op2)};
                F_SLL:         result = rt_val << shamt;
                F_SRL:         result = rt_val >> shamt;
                F_SRA:         result = $unsigned($signed(rt_val) >>> shamt);
`ifdef EX_MULDIV_EN
                F_MFHI:        result = hi;
                F_MFLO:        result = lo;
`endif
                default:       result = 32'd0;
            endcase
        end else begin
            case (opcode)
                OP_ADDI, OP_ADDIU: result = rs_val + op2;
                OP_SLTI:           result = {31'd0, $signed(rs_val) < $signed(op2)};
                OP_ANDI:           result = rs_val & op2;
                OP_ORI:            result = rs_val | op2;
                OP_XORI:           result = rs_val ^ op2;
                OP_LUI:            result = {instr_in[15:0], 16'h0};
                OP_LW, OP_SW:      result = rs_val + op2;
                default:           result = 32'd0;
            endcase
        end
    end

    // EX/MEM register; a stall inserts a bubble.
    always_ff @(posedge clock) begin
        if (reset || stall) begin
            alu_out         <= 32'd0;
            store_data_out  <= 32'd0;
            write_reg_out   <= 5'd0;
            reg_write_out   <= 1'b0;
            mem_reg_dst_out <= 1'b0;
            mem_write_out   <= 1'b0;
        end else begin
            alu_out         <= result;
            store_data_out  <= rt_val;
            write_reg_out   <= dest;
            reg_write_out   <= reg_write_in && !kill_write;
            mem_reg_dst_out <= mem_reg_dst_in;
            mem_write_out   <= mem_write_in;
        end
    end

endmodule
